// File: rtl/trans_link_pkg.sv
// Shared 8b/10b link word codes and TX framer state encoding.
// Used by trans_tx_framer and the far-end RX buffer controller.
package trans_link_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned K_W    = 2;

  // Per-byte K flag, bit0 belongs to data[7:0]
  localparam logic [K_W-1:0]    K_DATA = 2'b00;
  localparam logic [K_W-1:0]    K_CTRL = 2'b01;
  localparam logic [K_W-1:0]    K_FILL = 2'b11;

  localparam logic [WORD_W-1:0] D_IDLE = 16'h50BC;
  localparam logic [WORD_W-1:0] D_FILL = 16'h1C1C;
  localparam logic [7:0]        C_SOF  = 8'hFB;
  localparam logic [7:0]        C_EOF  = 8'hFD;

  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [WORD_W-1:0] data;
  } tx_word_t;

  localparam tx_word_t WORD_IDLE = '{k: K_CTRL, data: D_IDLE};
  localparam tx_word_t WORD_FILL = '{k: K_FILL, data: D_FILL};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_CSUM,
    ST_EOF
  } tx_state_e;

endpackage

// File: rtl/trans_tx_framer.sv
// TX framer: idles, SOF, fixed-length payload with fill, optional checksum, EOF.
// Optional checksum word enabled by `define TX_FRAME_CHECKSUM_EN.
module trans_tx_framer
  import trans_link_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned IDLE_GAP  = 4
) (
  input  logic        clk_trans,
  input  logic        reset,
  input  logic        link_ready,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] tx_parallel_data,
  output logic [1:0]  tx_datak,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [15:0] frame_count,
  output logic [7:0]  abort_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(IDLE_GAP);
  localparam logic [CNT_W-1:0] GAP_GO   = CNT_W'(IDLE_GAP - 1);

  tx_state_e        state_q;
  tx_word_t         word_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] pay_q;
  logic [7:0]       seq_q;
  logic             done_q;
  logic             abort_q;
  logic [15:0]      fcnt_q;
  logic [7:0]       acnt_q;
`ifdef TX_FRAME_CHECKSUM_EN
  logic [15:0]      csum_q;
`endif

  assign in_ready         = (state_q == ST_PAYLOAD) && link_ready;
  assign tx_parallel_data = word_q.data;
  assign tx_datak         = word_q.k;
  assign busy             = (state_q != ST_IDLE);
  assign frame_done       = done_q;
  assign frame_abort      = abort_q;
  assign frame_count      = fcnt_q;
  assign abort_count      = acnt_q;

  // gap_q counts idle words already on the wire since EOF/abort/reset
  always_ff @(posedge clk_trans or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= WORD_IDLE;
      gap_q   <= '0;
      pay_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      fcnt_q  <= '0;
      acnt_q  <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      word_q  <= WORD_IDLE;
      if ((state_q != ST_IDLE) && !link_ready) begin
        // Drop the frame without EOF; seq is reused by the next frame
        state_q <= ST_IDLE;
        gap_q   <= '0;
        abort_q <= 1'b1;
        if (acnt_q != 8'hFF) acnt_q <= acnt_q + 8'd1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (gap_q < GAP_MAX) gap_q <= gap_q + CNT_W'(1);
            if ((gap_q >= GAP_GO) && link_ready && in_valid) state_q <= ST_SOF;
          end
          ST_SOF: begin
            word_q  <= '{k: K_CTRL, data: {seq_q, C_SOF}};
            pay_q   <= '0;
`ifdef TX_FRAME_CHECKSUM_EN
            csum_q  <= '0;
`endif
            state_q <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            if (in_valid) begin
              word_q <= '{k: K_DATA, data: in_data};
              pay_q  <= pay_q + CNT_W'(1);
`ifdef TX_FRAME_CHECKSUM_EN
              csum_q <= csum_q + in_data;
              if (pay_q == LAST_IDX) state_q <= ST_CSUM;
`else
              if (pay_q == LAST_IDX) state_q <= ST_EOF;
`endif
            end else begin
              word_q <= WORD_FILL;
            end
          end
`ifdef TX_FRAME_CHECKSUM_EN
          ST_CSUM: begin
            word_q  <= '{k: K_DATA, data: csum_q};
            state_q <= ST_EOF;
          end
`endif
          ST_EOF: begin
            word_q  <= '{k: K_CTRL, data: {seq_q, C_EOF}};
            done_q  <= 1'b1;
            fcnt_q  <= fcnt_q + 16'd1;
            seq_q   <= seq_q + 8'd1;
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
